collision_detector: RTL and testbench

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector.sv | 120 ++++++++++++
 tb/tb_collision_detector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// Per-pixel collision detection with per-frame OR summary and a saturating enemy-hit run counter.
// Optional build macro COLLISION_ONE_SHOT_EN limits player/enemy and player/enemy-missile hits to one pulse per frame.
module collision_detector #(
  parameter int HIT_COUNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       playerDR,
  input  logic                       playerMissileDR,
  input  logic                       enemyDR,
  input  logic                       enemyMissileDR,
  input  logic                       boundaryDR,
  input  logic                       farBoundaryDR,
  output logic [5:0]                 collision,
  output logic [5:0]                 frameCollision,
  output logic [HIT_COUNT_WIDTH-1:0] enemyHitCount
);

  localparam int COLLISION_PLAYER_ENEMY         = 0;
  localparam int COLLISION_PLAYER_ENEMY_MISSILE = 1;
  localparam int COLLISION_ENEMY_MISSILE        = 2;
  localparam int COLLISION_PLAYER_BOUNDARY      = 3;
  localparam int COLLISION_ENEMY_FAR_BOUNDARY   = 4;
  localparam int COLLISION_MISSILE_BOUNDARY     = 5;

  localparam logic [HIT_COUNT_WIDTH-1:0] HIT_MAX = '1;
  localparam logic [HIT_COUNT_WIDTH-1:0] HIT_ONE = HIT_COUNT_WIDTH'(1);

  logic [5:0]                 rawCollision;
  logic [5:0]                 gatedCollision;
  logic [5:0]                 accumulator;
  logic [HIT_COUNT_WIDTH-1:0] hitCounter;
  logic [HIT_COUNT_WIDTH-1:0] hitCounterNext;
  logic                       prevEnemyHit;
  logic                       hitEdge;

  always_comb begin
    rawCollision = '0;
    rawCollision[COLLISION_PLAYER_ENEMY]         = playerDR & enemyDR;
    rawCollision[COLLISION_PLAYER_ENEMY_MISSILE] = playerDR & enemyMissileDR;
    rawCollision[COLLISION_ENEMY_MISSILE]        = enemyDR & playerMissileDR;
    rawCollision[COLLISION_PLAYER_BOUNDARY]      = playerDR & boundaryDR;
    rawCollision[COLLISION_ENEMY_FAR_BOUNDARY]   = enemyDR & farBoundaryDR;
    rawCollision[COLLISION_MISSILE_BOUNDARY]     = (playerMissileDR | enemyMissileDR) & boundaryDR;
  end

`ifdef COLLISION_ONE_SHOT_EN
  // A hit arriving with startOfFrame belongs to the new frame, so it passes and arms the fresh mask.
  logic [1:0] oneShotMask;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gOneShot
      assign gatedCollision[gi] = rawCollision[gi] & (~oneShotMask[gi] | startOfFrame);

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          oneShotMask[gi] <= 1'b0;
        end else if (startOfFrame) begin
          oneShotMask[gi] <= gatedCollision[gi];
        end else if (gatedCollision[gi]) begin
          oneShotMask[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign gatedCollision[5:2] = rawCollision[5:2];
`else
  assign gatedCollision = rawCollision;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      collision <= '0;
    end else begin
      collision <= gatedCollision;
    end
  end

  // The registered value present at startOfFrame still belongs to the closing frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      accumulator    <= '0;
      frameCollision <= '0;
    end else if (startOfFrame) begin
      accumulator    <= '0;
      frameCollision <= accumulator | collision;
    end else begin
      accumulator    <= accumulator | collision;
    end
  end

  assign hitEdge = collision[COLLISION_ENEMY_MISSILE] & ~prevEnemyHit;

  always_comb begin
    hitCounterNext = hitCounter;
    if (hitEdge && (hitCounter != HIT_MAX)) begin
      hitCounterNext = hitCounter + HIT_ONE;
    end
  end

  // prevEnemyHit survives frame boundaries so a run straddling startOfFrame is counted once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prevEnemyHit  <= 1'b0;
      hitCounter    <= '0;
      enemyHitCount <= '0;
    end else begin
      prevEnemyHit <= collision[COLLISION_ENEMY_MISSILE];
      if (startOfFrame) begin
        enemyHitCount <= hitCounterNext;
        hitCounter    <= '0;
      end else begin
        hitCounter    <= hitCounterNext;
      end
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: stimulus queues expected outputs, a monitor pops and compares.
module tb_collision_detector;

  localparam logic [5:0] P  = 6'b000001;
  localparam logic [5:0] PM = 6'b000010;
  localparam logic [5:0] E  = 6'b000100;
  localparam logic [5:0] EM = 6'b001000;
  localparam logic [5:0] B  = 6'b010000;
  localparam logic [5:0] FB = 6'b100000;

`ifdef COLLISION_ONE_SHOT_EN
  localparam bit ONE_SHOT = 1'b1;
`else
  localparam bit ONE_SHOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       playerDR = 1'b0;
  logic       playerMissileDR = 1'b0;
  logic       enemyDR = 1'b0;
  logic       enemyMissileDR = 1'b0;
  logic       boundaryDR = 1'b0;
  logic       farBoundaryDR = 1'b0;
  logic [5:0] collision;
  logic [5:0] frameCollision;
  logic [7:0] enemyHitCount;

  collision_detector #(.HIT_COUNT_WIDTH(8)) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .playerDR(playerDR),
    .playerMissileDR(playerMissileDR),
    .enemyDR(enemyDR),
    .enemyMissileDR(enemyMissileDR),
    .boundaryDR(boundaryDR),
    .farBoundaryDR(farBoundaryDR),
    .collision(collision),
    .frameCollision(frameCollision),
    .enemyHitCount(enemyHitCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [5:0] coll;
    logic [5:0] frame;
    logic [7:0] hits;
    bit         sof;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [5:0] expFrame = '0;
  logic [7:0] expHits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got 0x%0h expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares every queued expectation whose cycle tag has been reached.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        checkField("tag_alignment", 32'(cyc), 32'(e.tag));
        checkField("collision", 32'(collision), 32'(e.coll));
        checkField("frameCollision", 32'(frameCollision), 32'(e.frame));
        checkField("enemyHitCount", 32'(enemyHitCount), 32'(e.hits));
        if (e.sof)
          $display("frame close cyc=%0d frameCollision=%b enemyHitCount=%0d", cyc, frameCollision, enemyHitCount);
      end
    end
  end

  task automatic step(input logic [5:0] in, input logic sof, input logic [5:0] eColl);
    @(negedge clk);
    {farBoundaryDR, boundaryDR, enemyMissileDR, enemyDR, playerMissileDR, playerDR} = in;
    startOfFrame = sof;
    q.push_back('{cyc + 1, eColl, expFrame, expHits, sof});
  endtask

  task automatic closeFrame(input logic [5:0] in, input logic [5:0] eColl,
                            input logic [5:0] frame, input logic [7:0] hits);
    expFrame = frame;
    expHits  = hits;
    step(in, 1'b1, eColl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'd0, 1'b0, 6'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    checkField("queue_drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkField("reset_collision", 32'(collision), 32'd0);
    checkField("reset_frameCollision", 32'(frameCollision), 32'd0);
    checkField("reset_enemyHitCount", 32'(enemyHitCount), 32'd0);
    resetN = 1'b1;

    // Single-cycle enemy/missile hit
    closeFrame(6'd0, 6'd0, 6'd0, 8'd0);
    idle(9);
    step(E | PM, 1'b0, 6'b000100);
    step(6'd0, 1'b0, 6'd0);
    idle(3);
    closeFrame(6'd0, 6'd0, 6'b000100, 8'd1);

    // Two 5-cycle runs
    for (int i = 0; i < 5; i++) step(E | PM, 1'b0, 6'b000100);
    idle(3);
    for (int i = 0; i < 5; i++) step(E | PM, 1'b0, 6'b000100);
    idle(2);
    closeFrame(6'd0, 6'd0, 6'b000100, 8'd2);

    // 300 runs saturate an 8-bit counter
    for (int i = 0; i < 300; i++) begin
      step(E | PM, 1'b0, 6'b000100);
      step(6'd0, 1'b0, 6'd0);
    end
    closeFrame(6'd0, 6'd0, 6'b000100, 8'd255);

    // Player/enemy overlap for 4 cycles, then again after a frame boundary
    step(P | E, 1'b0, 6'b000001);
    for (int i = 0; i < 3; i++) step(P | E, 1'b0, ONE_SHOT ? 6'd0 : 6'b000001);
    step(6'd0, 1'b0, 6'd0);
    closeFrame(6'd0, 6'd0, 6'b000001, 8'd0);
    step(P | E, 1'b0, 6'b000001);
    step(6'd0, 1'b0, 6'd0);
    closeFrame(6'd0, 6'd0, 6'b000001, 8'd0);

    // Far-boundary hit registered in the startOfFrame cycle
    step(E | FB, 1'b0, 6'b010000);
    closeFrame(6'd0, 6'd0, 6'b010000, 8'd0);
    idle(3);
    closeFrame(6'd0, 6'd0, 6'd0, 8'd0);

    // Hit run straddling startOfFrame: counted once, in the closing frame
    step(E | PM, 1'b0, 6'b000100);
    closeFrame(E | PM, 6'b000100, 6'b000100, 8'd1);
    step(E | PM, 1'b0, 6'b000100);
    step(6'd0, 1'b0, 6'd0);
    closeFrame(6'd0, 6'd0, 6'b000100, 8'd0);

    // Player/enemy overlap coincident with startOfFrame
    step(P | E, 1'b0, 6'b000001);
    step(P | E, 1'b0, ONE_SHOT ? 6'd0 : 6'b000001);
    closeFrame(P | E, 6'b000001, 6'b000001, 8'd0);
    step(P | E, 1'b0, ONE_SHOT ? 6'd0 : 6'b000001);
    step(6'd0, 1'b0, 6'd0);
    closeFrame(6'd0, 6'd0, 6'b000001, 8'd0);

    // Mid-frame asynchronous reset with pending detections and hits
    step(P | E | B, 1'b0, 6'b001001);
    step(6'd0, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      step(E | PM, 1'b0, 6'b000100);
      step(6'd0, 1'b0, 6'd0);
    end
    drain();
    @(negedge clk);
    startOfFrame = 1'b0;
    #2 resetN = 1'b0;
    #1;
    checkField("async_reset_collision", 32'(collision), 32'd0);
    checkField("async_reset_frameCollision", 32'(frameCollision), 32'd0);
    checkField("async_reset_enemyHitCount", 32'(enemyHitCount), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    closeFrame(6'd0, 6'd0, 6'd0, 8'd0);
    idle(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
